// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the combinational instruction-memory
// read port and registers the fetched word into a valid/ready output stage.
module inst_fetch_unit #(
    parameter int unsigned                  INST_LENGTH        = 32,
    parameter int unsigned                  INSTMEM_ADDR_WIDTH = 16,
    parameter logic [INSTMEM_ADDR_WIDTH-1:0] RESET_PC          = '0,
    parameter logic [5:0]                   HALT_OPCODE        = 6'b111111
) (
    input  logic                          clk,
    input  logic                          rst_n,
    output logic [INSTMEM_ADDR_WIDTH-1:0] imem_addr,
    input  logic [INST_LENGTH-1:0]        imem_data,
    input  logic                          redirect_valid,
    input  logic [INSTMEM_ADDR_WIDTH-1:0] redirect_pc,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [INST_LENGTH-1:0]        instr_out,
    output logic [INSTMEM_ADDR_WIDTH-1:0] pc_out,
    output logic                          halted
);

    localparam int unsigned OPC_W = 6;

    typedef enum logic {
        FETCH  = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t                          state;
    state_t                          state_next;
    logic [INSTMEM_ADDR_WIDTH-1:0]   pc;
    logic [INSTMEM_ADDR_WIDTH-1:0]   pc_next;
    logic                            out_valid_next;
    logic [INST_LENGTH-1:0]          instr_next;
    logic [INSTMEM_ADDR_WIDTH-1:0]   pc_out_next;
    logic                            load_c;
    logic                            is_halt_c;

    // Address comes straight from the PC register so the memory sees it the same cycle.
    assign imem_addr = pc;
    assign halted    = (state == HALTED);

    assign is_halt_c = (imem_data[INST_LENGTH-1 -: OPC_W] == HALT_OPCODE);
    assign load_c    = (state == FETCH) && !redirect_valid && (!out_valid || out_ready);

    // Next-state and output-stage update; redirect overrides everything else.
    always_comb begin
        state_next     = state;
        pc_next        = pc;
        out_valid_next = out_valid;
        instr_next     = instr_out;
        pc_out_next    = pc_out;

        if (redirect_valid) begin
            pc_next        = redirect_pc;
            out_valid_next = 1'b0;
            state_next     = FETCH;
        end else if (load_c) begin
            instr_next     = imem_data;
            pc_out_next    = pc;
            out_valid_next = 1'b1;
            if (is_halt_c) begin
                state_next = HALTED;
            end else begin
                pc_next = pc + INSTMEM_ADDR_WIDTH'(1);
            end
        end else if (out_valid && out_ready) begin
            out_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            out_valid <= 1'b0;
            instr_out <= '0;
            pc_out    <= '0;
        end else begin
            state     <= state_next;
            pc        <= pc_next;
            out_valid <= out_valid_next;
            instr_out <= instr_next;
            pc_out    <= pc_out_next;
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: memory model, transfer scoreboard and
// point checks of handshake, redirect, halt, wrap-around and async reset.
module tb_inst_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [15:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr_out;
    logic [15:0] pc_out;
    logic        halted;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [15:0] pc;
        logic [31:0] instr;
    } xfer_t;

    xfer_t sb_q[$];

    inst_fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .instr_out      (instr_out),
        .pc_out         (pc_out),
        .halted         (halted)
    );

    // Word 5 is HALT; every other word carries opcode 1 and its own address.
    function automatic logic [31:0] mem_word(input logic [15:0] a);
        if (a == 16'd5) return 32'hFC00_0000;
        return 32'h0400_0000 | 32'(a);
    endfunction

    assign imem_data = mem_word(imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] a);
        xfer_t e;
        e.pc    = a;
        e.instr = mem_word(a);
        sb_q.push_back(e);
    endtask

    // A transfer happens at the coming edge when valid&&ready and no redirect flushes it.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready && !redirect_valid) begin
            xfer_t e;
            if (sb_q.size() == 0) begin
                check("sb_unexpected_xfer_pc", 32'(pc_out), 32'hFFFF_FFFF);
            end else begin
                e = sb_q.pop_front();
                check("sb_xfer_pc", 32'(pc_out), 32'(e.pc));
                check("sb_xfer_instr", instr_out, e.instr);
            end
        end
    end

    initial begin
        rst_n          = 1'b1;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_instr", instr_out, 32'd0);
        check("rst_pc_out", 32'(pc_out), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_addr", 32'(imem_addr), 32'd0);
        #9 out_ready = 1'b1;
        push(16'd0);
        push(16'd1);
        rst_n = 1'b1;

        // free run
        step();
        check("fr_valid0", 32'(out_valid), 32'd1);
        check("fr_instr0", instr_out, mem_word(16'd0));
        check("fr_pc0", 32'(pc_out), 32'd0);
        step();
        out_ready = 1'b0;
        check("fr_instr1", instr_out, mem_word(16'd1));
        check("fr_pc1", 32'(pc_out), 32'd1);
        check("fr_addr2", 32'(imem_addr), 32'd2);

        // backpressure
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_instr", instr_out, mem_word(16'd1));
            check("bp_pc", 32'(pc_out), 32'd1);
            check("bp_addr", 32'(imem_addr), 32'd2);
        end
        out_ready = 1'b1;
        step();
        check("bp_next_instr", instr_out, mem_word(16'd2));
        check("bp_next_pc", 32'(pc_out), 32'd2);

        // redirect during stall flushes A2
        out_ready      = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0040;
        step();
        check("rd_flush_valid", 32'(out_valid), 32'd0);
        check("rd_addr", 32'(imem_addr), 32'h40);
        redirect_valid = 1'b0;
        step();
        check("rd_tgt_valid", 32'(out_valid), 32'd1);
        check("rd_tgt_instr", instr_out, mem_word(16'h0040));
        check("rd_tgt_pc", 32'(pc_out), 32'h40);
        push(16'h0040);
        out_ready = 1'b1;
        step();

        // redirect with out_ready high still flushes the buffered 0x41
        redirect_valid = 1'b1;
        redirect_pc    = 16'd4;
        step();
        check("rd_rdy_flush_valid", 32'(out_valid), 32'd0);
        check("rd_rdy_addr", 32'(imem_addr), 32'd4);
        redirect_valid = 1'b0;
        push(16'd4);
        push(16'd5);

        // halt
        step();
        check("h_pc4", 32'(pc_out), 32'd4);
        check("h_not_halted", 32'(halted), 32'd0);
        step();
        check("h_instr", instr_out, 32'hFC00_0000);
        check("h_pc5", 32'(pc_out), 32'd5);
        check("h_halted", 32'(halted), 32'd1);
        check("h_addr", 32'(imem_addr), 32'd5);
        for (int i = 0; i < 2; i++) begin
            step();
            check("h_idle_valid", 32'(out_valid), 32'd0);
            check("h_idle_halted", 32'(halted), 32'd1);
            check("h_idle_addr", 32'(imem_addr), 32'd5);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 16'd0;
        for (int i = 0; i < 2; i++) begin
            step();
            check("h_exit_halted", 32'(halted), 32'd0);
            check("h_exit_valid", 32'(out_valid), 32'd0);
            check("h_exit_addr", 32'(imem_addr), 32'd0);
        end
        redirect_valid = 1'b0;
        push(16'd0);
        step();
        check("h_resume_instr", instr_out, mem_word(16'd0));
        check("h_resume_valid", 32'(out_valid), 32'd1);
        step();

        // wrap-around
        redirect_valid = 1'b1;
        redirect_pc    = 16'hFFFF;
        step();
        check("w_flush_valid", 32'(out_valid), 32'd0);
        check("w_addr", 32'(imem_addr), 32'hFFFF);
        redirect_valid = 1'b0;
        push(16'hFFFF);
        step();
        check("w_pc_ffff", 32'(pc_out), 32'hFFFF);
        check("w_addr0", 32'(imem_addr), 32'd0);
        step();
        check("w_pc0", 32'(pc_out), 32'd0);
        check("w_instr0", instr_out, mem_word(16'd0));
        check("w_addr1", 32'(imem_addr), 32'd1);

        // asynchronous reset between edges
        #2 rst_n = 1'b0;
        #1;
        check("ar_valid", 32'(out_valid), 32'd0);
        check("ar_addr", 32'(imem_addr), 32'd0);
        check("ar_pc_out", 32'(pc_out), 32'd0);
        check("ar_instr", instr_out, 32'd0);
        out_ready = 1'b0;
        #3 rst_n = 1'b1;
        step();
        check("ar_restart_valid", 32'(out_valid), 32'd1);
        check("ar_restart_instr", instr_out, mem_word(16'd0));
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
